// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// default geometry.
package imem_pkg;

    localparam int IMEM_WORDS_DEF = 64;
    localparam int IMEM_AW_DEF    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words; full flags that the next
// shift completes the current word.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [31:0] pack;
    logic [1:0]  byte_cnt;

    // byte_cnt wraps 3->0 on its own, so no clear is needed between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            pack     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            pack     <= {pack[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_out = pack;
    assign full     = (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory while stalling the CPU; in IDLE the
// memory address follows the CPU fetch address.
module imem_loader
    import imem_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int IMEM_AW    = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               byte_valid,
    input  logic [7:0]         byte_in,
    output logic               byte_ready,
    input  logic [IMEM_AW-1:0] pc_addr,
    output logic [IMEM_AW-1:0] mem_addr,
    output logic               mem_we,
    output logic [31:0]        mem_wdata,
    output logic               cpu_stall,
    output logic               busy,
    output logic               load_done
);

    localparam logic [IMEM_AW-1:0] LAST_IDX = IMEM_AW'(IMEM_WORDS - 1);

    imem_state_e        state;
    logic [IMEM_AW-1:0] word_idx;
    logic               rdy_q, we_q, busy_q, done_q;
    logic               in_load, in_xfer, shift_en, clr, full;
    logic [31:0]        word_out;

    assign in_load  = (state == ST_LOAD);
    assign in_xfer  = (state == ST_LOAD) || (state == ST_WRITE);
    // abort wins over byte acceptance and drops any partial word
    assign shift_en = in_load && byte_valid && !abort;
    assign clr      = in_xfer && abort;

    imem_word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_en),
        .byte_in  (byte_in),
        .word_out (word_out),
        .full     (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_LOAD;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        word_idx <= '0;
                        rdy_q    <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (shift_en && full) begin
                        state <= ST_WRITE;
                        rdy_q <= 1'b0;
                        we_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    we_q <= 1'b0;
                    if (abort) begin
                        state    <= ST_IDLE;
                        word_idx <= '0;
                        busy_q   <= 1'b0;
                    end else if (word_idx == LAST_IDX) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state    <= ST_LOAD;
                        word_idx <= word_idx + 1'b1;
                        rdy_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    word_idx <= '0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The write strobe is gated live so an abort in WRITE suppresses it that cycle.
    assign mem_we     = we_q && !abort;
    assign mem_wdata  = word_out;
    assign mem_addr   = (state == ST_IDLE) ? pc_addr : word_idx;
    assign byte_ready = rdy_q;
    assign busy       = busy_q;
    assign cpu_stall  = busy_q;
    assign load_done  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a cycle-level reference of the byte
// handshake and a word-level memory image built from the byte stream.
module tb_imem_loader;

    localparam int W   = 64;
    localparam int AW  = 6;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, byte_valid;
    logic [7:0]    byte_in;
    logic          byte_ready;
    logic [AW-1:0] pc_addr, mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          cpu_stall, busy, load_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  bytes [256];
    logic [31:0] tbmem [W];

    always #5 clk = ~clk;

    imem_loader #(.IMEM_WORDS(W), .IMEM_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .pc_addr    (pc_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_stall  (cpu_stall),
        .busy       (busy),
        .load_done  (load_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_stall"}, 32'(cpu_stall), 0);
        chk({pfx, "_busy"},  32'(busy), 0);
        chk({pfx, "_done"},  32'(load_done), 0);
        chk({pfx, "_we"},    32'(mem_we), 0);
        chk({pfx, "_rdy"},   32'(byte_ready), 0);
        chk({pfx, "_wdata"}, mem_wdata, 0);
        chk({pfx, "_addr"},  32'(mem_addr), 32'(pc_addr));
    endtask

    // mode: 0 continuous valid, 1 toggled valid, 2 random valid + random data.
    // abort_byte / abort_wr / rst_byte < 0 disable that disturbance.
    task automatic run_load(input int mode, input int abort_byte, input int abort_wr,
                            input int rst_byte, input bit noisy);
        int n, nacc, wr_due, wr_word, done_due, ended;
        int err_rdy, err_we, err_stall, err_done, n_done, done_cyc, nwr, bad, quiet, exp_words;
        bit v, exp_rdy, exp_we;
        for (int i = 0; i < 256; i++) bytes[i] = (mode == 2) ? 8'($urandom) : 8'(i);
        for (int i = 0; i < W; i++) tbmem[i] = SENT;
        nacc = 0; wr_due = -1; wr_word = -1; done_due = -1; ended = 0;
        err_rdy = 0; err_we = 0; err_stall = 0; err_done = 0;
        n_done = 0; done_cyc = -1; nwr = 0;

        @(negedge clk);
        start = 1'b1;
        abort = noisy;
        byte_valid = noisy;
        byte_in = 8'hA5;
        for (n = 1; n < 3000 && ended == 0; n++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
            if (noisy) pc_addr = AW'($urandom);
            exp_rdy = (n != wr_due) && (n != done_due);
            exp_we  = (n == wr_due);
            if (byte_ready !== exp_rdy) err_rdy++;
            if (mem_we !== exp_we) err_we++;
            if (cpu_stall !== 1'b1 || busy !== 1'b1) err_stall++;
            if (load_done !== (n == done_due)) err_done++;
            if (load_done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = n;
            end

            if (n == done_due) begin
                // abort and start in the completion cycle must be harmless
                abort = noisy;
                start = noisy;
                ended = 1;
            end else if (abort_wr >= 0 && n == wr_due && wr_word == abort_wr) begin
                abort = 1'b1;
                #1 chk("abort_wr_we", 32'(mem_we), 0);
                ended = 2;
            end else if (abort_byte >= 0 && nacc == abort_byte && exp_rdy) begin
                abort = 1'b1;
                byte_valid = 1'b1;
                byte_in = bytes[nacc];
                ended = 2;
            end else if (rst_byte >= 0 && nacc == rst_byte && exp_rdy) begin
                byte_valid = 1'b1;
                byte_in = bytes[nacc];
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 chk_reset_outputs("midrst");
                repeat (2) begin
                    @(negedge clk);
                    if (mem_we !== 1'b0 || busy !== 1'b0) err_we++;
                end
                rst_n = 1'b1;
                ended = 3;
            end else begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 1) : 1'($urandom_range(0, 1));
                if (noisy && $urandom_range(0, 7) == 0) start = 1'b1;
                byte_valid = v;
                byte_in = v ? bytes[nacc] : 8'($urandom);
                if (exp_rdy && v) begin
                    if (nacc % 4 == 3) begin
                        wr_due = n + 1;
                        wr_word = nacc / 4;
                        if (wr_word == W - 1) done_due = n + 2;
                    end
                    nacc++;
                end
            end

            if (mem_we === 1'b1) begin
                if (mem_addr !== wr_word[AW-1:0]) err_we++;
                tbmem[mem_addr] = mem_wdata;
                nwr++;
            end
        end
        if (ended == 0) chk("timeout", 1, 0);

        @(negedge clk);
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        chk("post_busy",  32'(busy), 0);
        chk("post_stall", 32'(cpu_stall), 0);
        quiet = 0;
        repeat (6) begin
            if (mem_we !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0) quiet++;
            @(negedge clk);
        end
        chk("post_quiet", quiet, 0);

        exp_words = (ended == 1) ? W : (ended == 2 && abort_wr >= 0) ? abort_wr : nacc / 4;
        chk("rdy_err",   err_rdy, 0);
        chk("we_err",    err_we, 0);
        chk("stall_err", err_stall, 0);
        chk("done_err",  err_done, 0);
        chk("n_done",    n_done, (ended == 1) ? 1 : 0);
        chk("n_wr",      nwr, exp_words);
        bad = 0;
        for (int k = 0; k < exp_words; k++)
            if (tbmem[k] !== {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]}) bad++;
        chk("words", bad, 0);
        if (exp_words < W) chk("untouched", tbmem[exp_words], SENT);
        if (mode < 2 && ended == 1) begin
            chk("w0",  tbmem[0],  32'h00010203);
            chk("w63", tbmem[63], 32'hFCFDFEFF);
            if (mode == 0) chk("done_cyc", done_cyc, 5 * W + 1);
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        byte_in = 8'h00; pc_addr = 6'h13;
        #2 rst_n = 1'b0;
        #10 chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        pc_addr = 6'h2A;
        #1;
        chk("pass_addr", 32'(mem_addr), 32'h2A);
        chk("pass_we",   32'(mem_we), 0);
        for (int i = 0; i < 4; i++) begin
            pc_addr = AW'($urandom);
            #1 chk("pass_rand", 32'(mem_addr), 32'(pc_addr));
        end

        run_load(0, -1, -1, -1, 1'b0);  // full contiguous load
        run_load(1, -1, -1, -1, 1'b0);  // byte_valid toggling 1/0
        run_load(2, 22, -1, -1, 1'b1);  // abort after 2 bytes of word 5
        run_load(2, -1, 17, -1, 1'b1);  // abort on the write of word 17
        run_load(2, 42, -1, -1, 1'b0);  // abort after 2 bytes of word 10
        run_load(2, -1, -1, 42, 1'b1);  // async reset during word 10
        run_load(2, -1, -1, -1, 1'b1);  // restart from word 0 after reset
        run_load(2, -1, -1, -1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 64; the number of 32-bit words loaded per load sequence.
REQ-002 SHALL have parameter IMEM_AW, default 6; the instruction-memory address width.
REQ-003 SHALL have port clk, input, 1; the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst_n, input, 1; the reset, which is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1; a one-cycle request to begin a load sequence.
REQ-006 SHALL have port abort, input, 1; cancels a load in progress.
REQ-007 SHALL have port byte_valid, input, 1; marks byte_in as valid.
REQ-008 SHALL have port byte_in, input, 8; the load byte stream, most significant byte of each word first.
REQ-009 SHALL have port byte_ready, output, 1; shows the loader can accept a byte.
REQ-010 SHALL have port pc_addr, input, IMEM_AW; the CPU fetch address.
REQ-011 SHALL have port mem_addr, output, IMEM_AW; the address driven to the instruction memory.
REQ-012 SHALL have port mem_we, output, 1; the instruction-memory write enable.
REQ-013 SHALL have port mem_wdata, output, 32; the instruction-memory write data.
REQ-014 SHALL have port cpu_stall, output, 1; holds the CPU PC and pipeline while high.
REQ-015 SHALL have port busy, output, 1; high while a load is in progress.
REQ-016 SHALL have port load_done, output, 1; a one-cycle pulse when a load completes.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, WRITE and DONE.
REQ-018 SHALL move IDLE->LOAD on start=1, and otherwise stay in IDLE.
REQ-019 SHALL, in LOAD, drive byte_ready=1 and accept a byte on byte_valid&byte_ready, shifting it into a 32-bit pack register, MSB first.
REQ-020 SHALL move LOAD->WRITE on acceptance of the 4th byte of a word; byte_cnt is 2 bits and wraps 3->0.
REQ-021 SHALL, in WRITE, drive mem_we=1, mem_wdata=pack register, mem_addr=word_idx and byte_ready=0 for exactly one cycle.
REQ-022 SHALL, in WRITE, go to DONE if word_idx==IMEM_WORDS-1; otherwise it increments word_idx and returns to LOAD.
REQ-023 SHALL, in DONE, assert load_done=1 for one cycle and then return to IDLE with word_idx=0.
REQ-024 SHALL drive cpu_stall=1 and busy=1 in LOAD, WRITE and DONE, and 0 in IDLE.
REQ-025 SHALL drive mem_addr=pc_addr combinationally in IDLE, and drive mem_addr=word_idx in every other state.
REQ-026 SHALL drive mem_we=0 in every state except WRITE.
REQ-027 SHALL keep a byte-to-write latency of exactly 1 cycle from the 4th byte accepted to mem_we.
REQ-028 SHALL allow a minimum load time of 5*IMEM_WORDS+1 cycles from start.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL treat abort=1 in LOAD or WRITE as follows: next state IDLE, byte_cnt=0, word_idx=0, no mem_we that cycle, no load_done, and any partial word discarded.
REQ-031 SHALL give abort priority over byte acceptance and over the WRITE action in the same cycle.
REQ-032 SHALL have no effect from abort in IDLE or DONE.
REQ-033 SHALL hold the pack register, byte_cnt and word_idx while byte_valid=0 in LOAD.
REQ-034 SHALL ignore byte_valid in states other than LOAD.
REQ-035 SHALL start, when start and byte_valid are both high in IDLE, with the byte not accepted, so the first byte is accepted in LOAD.
REQ-036 SHALL keep already-written words intact in memory after an abort; a restart overwrites them from word 0.

Reset
REQ-037 SHALL, on rst_n=0, asynchronously set state=IDLE, byte_cnt=0, word_idx=0 and pack register=0.
REQ-038 SHALL hold outputs during reset at cpu_stall=0, busy=0, load_done=0, mem_we=0, byte_ready=0, mem_wdata=0 and mem_addr=pc_addr.
REQ-039 SHALL abandon a load when reset is applied mid-load, with no further write.
REQ-040 SHALL release reset synchronously with respect to FSM use, and the first transition SHALL be possible on the first rising clk edge after rst_n rises.

Structure
REQ-041 SHALL place the FSM state encoding, IMEM_WORDS_DEF=64 and IMEM_AW_DEF=6 in shared package imem_pkg.
REQ-042 SHALL implement byte packing (pack register plus byte_cnt) as sub-module imem_word_packer, with ports clk, rst_n, clr, shift_en, byte_in, word_out and full.
REQ-043 SHALL keep the top level to the FSM, word counter and address mux only.

Verification
REQ-044 SHALL verify a full load: start, then 256 bytes 00..FF with byte_valid held high, gives 64 writes, word 0=00010203 at addr 0 and word 63=FCFDFEFF at addr 63, one load_done pulse at cycle 321 after start, and cpu_stall high throughout.
REQ-045 SHALL verify a gapped stream: byte_valid toggled 1/0 gives the same memory contents as the full load, with mem_we only after each 4th accepted byte.
REQ-046 SHALL verify abort mid-word: abort after 2 bytes of word 5 gives no write to addr 5, IDLE the next cycle, cpu_stall=0, and no load_done.
REQ-047 SHALL verify fetch passthrough: in IDLE, pc_addr=0x2A drives mem_addr=0x2A in the same cycle, and mem_we=0.
REQ-048 SHALL verify async reset mid-load: rst_n low between clock edges during word 10 sets all outputs to their reset values immediately, and a new start then writes from addr 0.
REQ-049 SHALL verify a start during LOAD: it is ignored, with word_idx and byte_cnt unchanged.
